// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter for the multicycle core's data bus.
// Master 0 is the CPU load/store port and master 1 is the DMA/loader.
// Each transfer runs IDLE -> SETUP -> ACCESS -> DONE with an APB-style
// handshake, and a watchdog ends ACCESS phases that stall too long.
module bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16,
  parameter int PRIORITY_M0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_strb,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_strb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              m1_err,
  output logic [1:0]        grant,
  output logic              s_sel,
  output logic              s_enable,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [2:0]        s_strb,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             owner;
  logic             last_grant;
  logic             pick_m1;
  logic             any_req;
  logic             timeout_hit;

  assign any_req     = m0_req | m1_req;
  assign timeout_hit = (count == CNT_W'(TIMEOUT - 1));

  // Winner choice: a lone requester always wins; on a tie either m0 wins
  // outright or the master that did not own the bus last time wins.
  always_comb begin
    pick_m1 = 1'b0;
    if (m0_req && m1_req) begin
      if (PRIORITY_M0 != 0) begin
        pick_m1 = 1'b0;
      end else begin
        pick_m1 = ~last_grant;
      end
    end else begin
      pick_m1 = m1_req;
    end
  end

  // State register, forced back to IDLE the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: SETUP always lasts one cycle, ACCESS ends on slave
  // completion or watchdog expiry, DONE always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (s_ready || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer bookkeeping: latch the winner's request, run the watchdog,
  // and capture the completion result into the owning master's registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      grant      <= 2'b00;
      count      <= '0;
      s_write    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_strb     <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= pick_m1;
            last_grant <= pick_m1;
            grant      <= pick_m1 ? 2'b10 : 2'b01;
            s_write    <= pick_m1 ? m1_we    : m0_we;
            s_addr     <= pick_m1 ? m1_addr  : m0_addr;
            s_wdata    <= pick_m1 ? m1_wdata : m0_wdata;
            s_strb     <= pick_m1 ? m1_strb  : m0_strb;
          end
        end
        SETUP: begin
          count <= '0;
        end
        ACCESS: begin
          if (s_ready) begin
            if (owner) begin
              m1_rdata <= s_rdata;
              m1_err   <= 1'b0;
            end else begin
              m0_rdata <= s_rdata;
              m0_err   <= 1'b0;
            end
          end else if (timeout_hit) begin
            if (owner) begin
              m1_rdata <= '0;
              m1_err   <= 1'b1;
            end else begin
              m0_rdata <= '0;
              m0_err   <= 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          grant <= 2'b00;
        end
        default: begin
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign s_sel    = (state == SETUP) || (state == ACCESS);
  assign s_enable = (state == ACCESS);
  assign m0_ready = (state == DONE) && !owner;
  assign m1_ready = (state == DONE) && owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter. Two instances share every input: instance 0 is
// round-robin and instance 1 gives fixed priority to m0. Their bus phases
// stay in lockstep because phase timing never depends on who wins.
module tb_bus_arbiter;

  localparam int TO = 16;

  typedef struct {
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic [2:0]  strb0;
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [2:0]  strb1;
    logic        sready;
    logic [31:0] srdata;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic        sel;
    logic        en;
    logic [1:0]  grant;
    logic        rdy0;
    logic        rdy1;
    logic [31:0] rd0;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [2:0]  m0_strb, m1_strb;

  logic [31:0] o_m0_rdata [2];
  logic [31:0] o_m1_rdata [2];
  logic        o_m0_ready [2];
  logic        o_m1_ready [2];
  logic        o_m0_err   [2];
  logic        o_m1_err   [2];
  logic [1:0]  o_grant    [2];
  logic        o_sel      [2];
  logic        o_en       [2];
  logic        o_write    [2];
  logic [31:0] o_addr     [2];
  logic [31:0] o_wdata    [2];
  logic [2:0]  o_strb     [2];

  int checks = 0;
  int errors = 0;

  // Reference model: bus phase (0 idle, 1 setup, 2 access, 3 done), the
  // number of unanswered ACCESS cycles, and per-instance ownership/results.
  int          phase;
  int          waits;
  bit          mWin   [2];
  bit          mLast  [2];
  logic [31:0] mRd    [2][2];
  bit          mErr   [2][2];
  bit          mWe    [2];
  logic [31:0] mAddr  [2];
  logic [31:0] mWdata [2];
  logic [2:0]  mStrb  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .PRIORITY_M0(g)
    ) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_strb(m0_strb), .m0_rdata(o_m0_rdata[g]), .m0_ready(o_m0_ready[g]),
      .m0_err(o_m0_err[g]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_strb(m1_strb), .m1_rdata(o_m1_rdata[g]), .m1_ready(o_m1_ready[g]),
      .m1_err(o_m1_err[g]),
      .grant(o_grant[g]), .s_sel(o_sel[g]), .s_enable(o_en[g]),
      .s_write(o_write[g]), .s_addr(o_addr[g]), .s_wdata(o_wdata[g]),
      .s_strb(o_strb[g]), .s_rdata(s_rdata), .s_ready(s_ready)
    );
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.req0 = 0; s.we0 = 0; s.addr0 = 0; s.wdata0 = 0; s.strb0 = 0;
    s.req1 = 0; s.we1 = 0; s.addr1 = 0; s.wdata1 = 0; s.strb1 = 0;
    s.sready = 0; s.srdata = 0;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input logic sel, input logic en,
                                 input logic [1:0] gr, input logic r0, input logic r1,
                                 input logic [31:0] rd0);
    vec_t v;
    v.in = s; v.sel = sel; v.en = en; v.grant = gr;
    v.rdy0 = r0; v.rdy1 = r1; v.rd0 = rd0;
    return v;
  endfunction

  task automatic modelReset();
    phase = 0;
    waits = 0;
    for (int p = 0; p < 2; p++) begin
      mWin[p] = 0; mLast[p] = 1;
      mRd[p][0] = 0; mRd[p][1] = 0; mErr[p][0] = 0; mErr[p][1] = 0;
      mWe[p] = 0; mAddr[p] = 0; mWdata[p] = 0; mStrb[p] = 0;
    end
  endtask

  // Who gets the bus: a lone requester; on a tie m0 for the fixed-priority
  // instance, otherwise whoever did not own it last.
  function automatic bit pickM1(input int p);
    if (m0_req && m1_req) return (p == 1) ? 1'b0 : !mLast[p];
    return m1_req;
  endfunction

  task automatic modelEdge();
    case (phase)
      0: if (m0_req || m1_req) begin
        for (int p = 0; p < 2; p++) begin
          mWin[p]   = pickM1(p);
          mLast[p]  = mWin[p];
          mWe[p]    = mWin[p] ? m1_we    : m0_we;
          mAddr[p]  = mWin[p] ? m1_addr  : m0_addr;
          mWdata[p] = mWin[p] ? m1_wdata : m0_wdata;
          mStrb[p]  = mWin[p] ? m1_strb  : m0_strb;
        end
        phase = 1;
      end
      1: begin
        phase = 2;
        waits = 0;
      end
      2: if (s_ready) begin
        for (int p = 0; p < 2; p++) begin
          mRd[p][mWin[p]] = s_rdata; mErr[p][mWin[p]] = 0;
        end
        phase = 3;
      end else begin
        waits++;
        if (waits >= TO) begin
          for (int p = 0; p < 2; p++) begin
            mRd[p][mWin[p]] = 0; mErr[p][mWin[p]] = 1;
          end
          phase = 3;
        end
      end
      default: phase = 0;
    endcase
  endtask

  task automatic checkOutput();
    for (int p = 0; p < 2; p++) begin
      logic [1:0] g;
      g = (phase == 0) ? 2'b00 : (mWin[p] ? 2'b10 : 2'b01);
      checkEq($sformatf("dut%0d s_sel", p), o_sel[p], (phase == 1 || phase == 2));
      checkEq($sformatf("dut%0d s_enable", p), o_en[p], (phase == 2));
      checkEq($sformatf("dut%0d grant", p), o_grant[p], g);
      checkEq($sformatf("dut%0d m0_ready", p), o_m0_ready[p], (phase == 3 && !mWin[p]));
      checkEq($sformatf("dut%0d m1_ready", p), o_m1_ready[p], (phase == 3 && mWin[p]));
      checkEq($sformatf("dut%0d m0_err", p), o_m0_err[p], mErr[p][0]);
      checkEq($sformatf("dut%0d m1_err", p), o_m1_err[p], mErr[p][1]);
      checkEq($sformatf("dut%0d s_write", p), o_write[p], mWe[p]);
      checkEq($sformatf("dut%0d s_addr", p), o_addr[p], mAddr[p]);
      checkEq($sformatf("dut%0d s_wdata", p), o_wdata[p], mWdata[p]);
      checkEq($sformatf("dut%0d s_strb", p), o_strb[p], mStrb[p]);
      if (!mWe[p] || mErr[p][0]) checkEq($sformatf("dut%0d m0_rdata", p), o_m0_rdata[p], mRd[p][0]);
      if (!mWe[p] || mErr[p][1]) checkEq($sformatf("dut%0d m1_rdata", p), o_m1_rdata[p], mRd[p][1]);
    end
  endtask

  task automatic drive(input stim_t s);
    m0_req = s.req0; m0_we = s.we0; m0_addr = s.addr0; m0_wdata = s.wdata0; m0_strb = s.strb0;
    m1_req = s.req1; m1_we = s.we1; m1_addr = s.addr1; m1_wdata = s.wdata1; m1_strb = s.strb1;
    s_ready = s.sready; s_rdata = s.srdata;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic applyStimulus(input stim_t s);
    drive(s);
    @(posedge clk);
    if (reset) modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b0;
    drive(idleStim());
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic waitIdle();
    for (int c = 0; c < 40 && phase != 0; c++) applyStimulus(idleStim());
    checkEq("reach idle", phase, 0);
  endtask

  initial begin
    vec_t  vecs [5];
    stim_t s;
    int    n;
    int    acc;
    bit    seen;
    logic [1:0] gr [2][5];
    logic [1:0] expGr [2][5];

    drive(idleStim());
    modelReset();
    #2;
    checkOutput();
    @(negedge clk);
    reset = 1'b1;

    // Single m0 read, slave answers in its first ACCESS cycle.
    s = idleStim(); s.req0 = 1; s.addr0 = 32'h1000_0004;
    vecs[0] = mkVec(s, 1, 0, 2'b01, 0, 0, 32'h0);
    s.sready = 1; s.srdata = 32'hDEAD_BEEF;
    vecs[1] = mkVec(s, 1, 1, 2'b01, 0, 0, 32'h0);
    vecs[2] = mkVec(s, 0, 0, 2'b01, 1, 0, 32'hDEAD_BEEF);
    s = idleStim();
    vecs[3] = mkVec(s, 0, 0, 2'b00, 0, 0, 32'hDEAD_BEEF);
    s.sready = 1; s.srdata = 32'h5555_AAAA;
    vecs[4] = mkVec(s, 0, 0, 2'b00, 0, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].in);
      for (int p = 0; p < 2; p++) begin
        checkEq($sformatf("vec%0d dut%0d sel", i, p), o_sel[p], vecs[i].sel);
        checkEq($sformatf("vec%0d dut%0d en", i, p), o_en[p], vecs[i].en);
        checkEq($sformatf("vec%0d dut%0d grant", i, p), o_grant[p], vecs[i].grant);
        checkEq($sformatf("vec%0d dut%0d rdy0", i, p), o_m0_ready[p], vecs[i].rdy0);
        checkEq($sformatf("vec%0d dut%0d rdy1", i, p), o_m1_ready[p], vecs[i].rdy1);
        checkEq($sformatf("vec%0d dut%0d rd0", i, p), o_m0_rdata[p], vecs[i].rd0);
        checkEq($sformatf("vec%0d dut%0d err0", i, p), o_m0_err[p], 0);
      end
    end

    // Both masters hold requests; m0 drops after the fourth grant.
    doReset();
    expGr[0] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    expGr[1] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    s = idleStim(); s.req0 = 1; s.req1 = 1; s.sready = 1; s.srdata = 32'hA5A5_0001;
    n = 0;
    for (int c = 0; c < 80 && n < 5; c++) begin
      if (n == 4) s.req0 = 0;
      applyStimulus(s);
      if (o_sel[0] && !o_en[0]) begin
        gr[0][n] = o_grant[0];
        gr[1][n] = o_grant[1];
        n++;
      end
    end
    checkEq("grant sequence length", n, 5);
    for (int k = 0; k < n; k++) begin
      checkEq($sformatf("rr grant %0d", k), gr[0][k], expGr[0][k]);
      checkEq($sformatf("fixed grant %0d", k), gr[1][k], expGr[1][k]);
    end
    waitIdle();

    // m0 write with three slave wait states; m0 inputs scrambled after SETUP.
    s = idleStim(); s.req0 = 1; s.we0 = 1; s.addr0 = 32'h2000_0000;
    s.wdata0 = 32'h1234_5678; s.strb0 = 3'b010;
    applyStimulus(s);
    s = idleStim(); s.addr0 = 32'hFFFF_FFF0; s.wdata0 = 32'hBAD0_BAD0; s.strb0 = 3'b111;
    for (int k = 2; k <= 6; k++) begin
      s.sready = (k == 6);
      applyStimulus(s);
      s.addr0 = $urandom; s.wdata0 = $urandom;
      for (int p = 0; p < 2; p++) begin
        checkEq($sformatf("wr cyc%0d dut%0d addr", k, p), o_addr[p], 32'h2000_0000);
        checkEq($sformatf("wr cyc%0d dut%0d wdata", k, p), o_wdata[p], 32'h1234_5678);
        checkEq($sformatf("wr cyc%0d dut%0d strb", k, p), o_strb[p], 3'b010);
        checkEq($sformatf("wr cyc%0d dut%0d write", k, p), o_write[p], 1);
        checkEq($sformatf("wr cyc%0d dut%0d ready", k, p), o_m0_ready[p], (k == 6));
      end
    end
    waitIdle();

    // m1 read that the slave never answers, then one that it does.
    s = idleStim(); s.req1 = 1; s.addr1 = 32'h3000_0010;
    acc = 0; seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      applyStimulus(s);
      if (o_en[0]) acc++;
      if (o_m1_ready[0]) seen = 1;
    end
    checkEq("timeout ready seen", seen, 1);
    checkEq("timeout access cycles", acc, TO);
    checkEq("timeout m1_err", o_m1_err[0], 1);
    checkEq("timeout m1_rdata", o_m1_rdata[0], 0);
    s.req1 = 0;
    waitIdle();
    s = idleStim(); s.req1 = 1; s.sready = 1; s.srdata = 32'h0BAD_F00D;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      applyStimulus(s);
      if (o_m1_ready[0]) seen = 1;
    end
    checkEq("recovery ready seen", seen, 1);
    checkEq("recovery m1_err", o_m1_err[0], 0);
    checkEq("recovery m1_rdata", o_m1_rdata[0], 32'h0BAD_F00D);
    waitIdle();

    // Reset dropped in the middle of ACCESS while m0 keeps requesting.
    s = idleStim(); s.req0 = 1; s.addr0 = 32'h4000_0000;
    applyStimulus(s);
    applyStimulus(s);
    checkEq("pre-reset in access", o_en[0], 1);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    for (int p = 0; p < 2; p++) begin
      checkEq($sformatf("async rst dut%0d sel", p), o_sel[p], 0);
      checkEq($sformatf("async rst dut%0d en", p), o_en[p], 0);
      checkEq($sformatf("async rst dut%0d grant", p), o_grant[p], 0);
      checkEq($sformatf("async rst dut%0d ready", p), o_m0_ready[p], 0);
    end
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(s);
    checkEq("restart setup sel", o_sel[0], 1);
    checkEq("restart setup en", o_en[0], 0);
    checkEq("restart grant", o_grant[0], 2'b01);
    s.req0 = 0;
    waitIdle();

    // Random traffic against the model, including dropped requests and
    // input changes mid-transfer.
    for (int c = 0; c < 600; c++) begin
      s.req0 = ($urandom_range(0, 3) != 0);
      s.req1 = ($urandom_range(0, 3) != 0);
      s.we0 = $urandom_range(0, 1); s.we1 = $urandom_range(0, 1);
      s.addr0 = $urandom; s.addr1 = $urandom;
      s.wdata0 = $urandom; s.wdata1 = $urandom;
      s.strb0 = 3'($urandom_range(0, 7)); s.strb1 = 3'($urandom_range(0, 7));
      s.sready = ($urandom_range(0, 2) == 0);
      s.srdata = $urandom;
      applyStimulus(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
